// File: rtl/uart_baud_generator.sv
`default_nettype none
// ============================================================================
// uart_baud_generator : fractional-divisor Tx (1x) / Rx (OVERSAMPLE-x) tick
//                       generator with custom divisors, Rx resync and mid-bit
//                       strobe.
// Revision: 1.0
// ============================================================================
module uart_baud_generator #(
  parameter int CLK_FREQ   = 50000000,
  parameter int OVERSAMPLE = 16,
  parameter int FRAC_BITS  = 4,
  parameter int DIV_W      = 18
) (
  input  logic                       Clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [2:0]                 baud_select,
  input  logic                       use_custom,
  input  logic [DIV_W+FRAC_BITS-1:0] custom_tx_div,
  input  logic [DIV_W+FRAC_BITS-1:0] custom_rx_div,
  input  logic                       rx_resync,
  output logic                       tx_tick,
  output logic                       rx_tick,
  output logic                       rx_mid_tick
);

  localparam int DW    = DIV_W + FRAC_BITS;
  localparam int CW    = DIV_W + 1;
  localparam int PH_W  = $clog2(OVERSAMPLE);
  localparam int CFG_W = 1 + 3 + 2 * DW;

  function automatic logic [DW-1:0] table_div(input int idx, input int mult);
    longint baud;
    longint den;
    longint quot;
    case (idx)
      0:       baud = 300;
      1:       baud = 1200;
      2:       baud = 4800;
      3:       baud = 9600;
      4:       baud = 19200;
      5:       baud = 38400;
      6:       baud = 57600;
      default: baud = 115200;
    endcase
    den  = baud * longint'(mult);
    quot = ((longint'(CLK_FREQ) <<< FRAC_BITS) + den / 2) / den;
    return quot[DW-1:0];
  endfunction

  logic [DW-1:0] tx_table [8];
  logic [DW-1:0] rx_table [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_table
    localparam logic [DW-1:0] TX_DIV = table_div(gi, 1);
    localparam logic [DW-1:0] RX_DIV = table_div(gi, OVERSAMPLE);
    assign tx_table[gi] = TX_DIV;
    assign rx_table[gi] = RX_DIV;
  end

  // Divisor configuration latch; any difference from the live inputs restarts both channels.
  logic [CFG_W-1:0] cfg_q, cfg_d, cfg_in;
  logic             cfg_change;
  logic             cfg_use_custom;
  logic [2:0]       cfg_sel;
  logic [DW-1:0]    cfg_tx, cfg_rx;
  logic [DW-1:0]    tx_div, rx_div;

  always_comb begin
    cfg_in     = {use_custom, baud_select, custom_tx_div, custom_rx_div};
    cfg_change = (cfg_in != cfg_q);
    cfg_d      = cfg_change ? cfg_in : cfg_q;
    {cfg_use_custom, cfg_sel, cfg_tx, cfg_rx} = cfg_q;
    tx_div = tx_table[cfg_sel];
    rx_div = rx_table[cfg_sel];
    if (cfg_use_custom) begin
      tx_div = cfg_tx;
      rx_div = cfg_rx;
    end
  end

  always_ff @(posedge Clk) begin
    if (!reset) cfg_q <= cfg_in;
    else        cfg_q <= cfg_d;
  end

  logic [DW-1:0] chan_div [2];
  logic [1:0]    chan_restart;
  logic [1:0]    chan_term;
  logic [1:0]    chan_tick;

  assign chan_div[0] = tx_div;
  assign chan_div[1] = rx_div;

  always_comb begin
    chan_restart[0] = cfg_change | ~enable;
    chan_restart[1] = cfg_change | ~enable | rx_resync;
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic [CW-1:0]        cnt_q, cnt_d, last_cnt;
    logic [FRAC_BITS-1:0] acc_q, acc_d;
    logic                 carry_q, carry_d;
    logic                 start_q, start_d;
    logic                 tick_q, tick_d;
    logic [DIV_W-1:0]     int_part;
    logic [FRAC_BITS:0]   acc_sum;
    logic                 term;

    // start_q stretches the first period after a restart by one cycle.
    always_comb begin
      int_part = chan_div[ch][DW-1:FRAC_BITS];
      if (int_part < DIV_W'(2)) int_part = DIV_W'(2);
      acc_sum  = {1'b0, acc_q} + {1'b0, chan_div[ch][FRAC_BITS-1:0]};
      last_cnt = {1'b0, int_part} - CW'(1) + CW'(carry_q) + CW'(start_q);
      term     = (cnt_q == last_cnt);
      cnt_d    = cnt_q + CW'(1);
      acc_d    = acc_q;
      carry_d  = carry_q;
      start_d  = start_q;
      tick_d   = 1'b0;
      if (chan_restart[ch]) begin
        cnt_d   = '0;
        acc_d   = '0;
        carry_d = 1'b0;
        start_d = 1'b1;
      end else if (term) begin
        cnt_d   = '0;
        acc_d   = acc_sum[FRAC_BITS-1:0];
        carry_d = acc_sum[FRAC_BITS];
        start_d = 1'b0;
        tick_d  = 1'b1;
      end
    end

    always_ff @(posedge Clk) begin
      if (!reset) begin
        cnt_q   <= '0;
        acc_q   <= '0;
        carry_q <= 1'b0;
        start_q <= 1'b1;
        tick_q  <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        acc_q   <= acc_d;
        carry_q <= carry_d;
        start_q <= start_d;
        tick_q  <= tick_d;
      end
    end

    assign chan_term[ch] = term;
    assign chan_tick[ch] = tick_q;
  end

  // Phase counts Rx ticks since the last Rx restart; the mid strobe marks count OVERSAMPLE/2.
  logic [PH_W-1:0] phase_q, phase_d;
  logic            mid_q, mid_d;

  always_comb begin
    phase_d = phase_q;
    mid_d   = 1'b0;
    if (chan_restart[1]) begin
      phase_d = '0;
    end else if (chan_term[1]) begin
      phase_d = (phase_q == PH_W'(OVERSAMPLE - 1)) ? '0 : phase_q + PH_W'(1);
      mid_d   = (phase_q == PH_W'(OVERSAMPLE / 2 - 1));
    end
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      phase_q <= '0;
      mid_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      mid_q   <= mid_d;
    end
  end

  assign tx_tick     = chan_tick[0];
  assign rx_tick     = chan_tick[1];
  assign rx_mid_tick = mid_q;

endmodule
`default_nettype wire
